mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single unified instruction/data memory port of the multicycle MIPS core between two requesters: the CPU (controller/datapath) and a DMA/boot-loader engine.
- Sits between both requesters and the memory.
- Arbitrates each transaction round-robin, sequences the fixed-latency memory access, and returns read data with a one-cycle done pulse.
- The CPU controller holds its FSM state (stalls) until cpu_done.

Parameters:
- WIDTH, 32, data and address width in bits.
- LATENCY, 2, memory cycles from access start to valid mem_rdata; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- cpu_req  in  1  CPU transaction request; held with its fields until cpu_done.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  WIDTH  byte address.
- cpu_wdata  in  WIDTH  write data.
- cpu_rdata  out  WIDTH  registered read data.
- cpu_done  out  1  one-cycle completion pulse.
- dma_req, dma_we, dma_addr, dma_wdata, dma_rdata, dma_done: same directions, widths and meanings as the cpu_* ports, for the DMA requester.
- mem_en  out  1  memory access active.
- mem_we  out  1  memory write enable; only meaningful while mem_en = 1.
- mem_addr  out  WIDTH  memory address.
- mem_wdata  out  WIDTH  memory write data.
- mem_rdata  in  WIDTH  memory read data, valid LATENCY cycles after mem_en rises.
- owner  out  1  current or last grant: 0 = CPU, 1 = DMA.

Behaviour:
- Reset values:
  - state = IDLE, owner = 1, so the CPU wins the first tie.
  - mem_en, mem_we, cpu_done, dma_done = 0.
  - mem_addr, mem_wdata, cpu_rdata, dma_rdata = 0.
  - Beat counter = 0.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - Samples cpu_req and dma_req. Any req high in IDLE is a new request.
  - Only one high: that requester wins.
  - Both high: winner = !owner (round-robin).
  - On the next edge: owner <= winner; mem_addr/mem_we/mem_wdata are loaded from the winner's fields; mem_en <= 1; counter <= LATENCY-1; go to ACCESS.
  - Neither high: stay in IDLE, mem_en = 0.
- ACCESS:
  - mem_en = 1; mem_addr, mem_we and mem_wdata are held constant.
  - Counter decrements each cycle.
  - On the cycle counter == 0:
    - If the access is a read, the winner's rdata register captures mem_rdata.
    - mem_en <= 0, mem_we <= 0; go to RESP.
- RESP: the winner's done = 1 for exactly this cycle; go to IDLE.
- Latency: request sampled in cycle 0 → mem_en high in cycles 1..LATENCY → done high in cycle LATENCY+1. The first access after a completed transaction starts no earlier than LATENCY+2 cycles after the previous one started.
- Requester protocol:
  - The requester keeps req high and its fields stable through its done cycle.
  - If req is still high in the IDLE cycle after done, that is a new back-to-back request.
  - Dropping req mid-transaction does not cancel it: the access completes and done still pulses.
- Fairness: with both requesters continuously requesting, grants strictly alternate CPU, DMA, CPU, ...
- The loser's fields are ignored until it is granted. The loser's req is never lost, because the requester holds it.
- rdata:
  - Each requester's rdata is updated only by its own completed read.
  - It holds its value until that requester's next completed read.
  - Writes never modify any rdata.
- done exclusivity: cpu_done and dma_done are never high in the same cycle.
- Reset mid-operation: asserting reset in any state immediately (asynchronously) forces the reset values. The in-flight access is aborted, mem_en drops, and no done pulse is issued.
- Width rule: addresses pass through unmodified; no alignment checking.

Test Plan:
- Single CPU read, LATENCY=2:
  - Stimulus: cpu_req=1, cpu_we=0, cpu_addr=0x10; memory returns 0xDEADBEEF.
  - Required: mem_en high in cycles 1–2 with mem_addr=0x10; cpu_done high in cycle 3 only; cpu_rdata=0xDEADBEEF; dma_rdata=0.
- Simultaneous requests after reset:
  - Stimulus: cpu reads 0x4 and dma reads 0x8, both held high continuously.
  - Required: grant order CPU, DMA, CPU, DMA; owner toggles each transaction; done pulses every 4 cycles, alternating.
- DMA write:
  - Stimulus: dma_we=1, addr=0x20, wdata=0x12345678.
  - Required: mem_we=1 with those values during ACCESS; dma_done pulses; cpu_rdata and dma_rdata unchanged.
- Reset during ACCESS:
  - Stimulus: assert reset in the first ACCESS cycle of a CPU read.
  - Required: mem_en=0 at once; no cpu_done; after release, a new cpu_req completes normally.
- LATENCY=1 build:
  - Stimulus: CPU read of 0x0 returning 0xA5A5A5A5.
  - Required: mem_en for exactly 1 cycle; cpu_done in cycle 2; rdata correct.
- req dropped mid-transaction:
  - Stimulus: cpu_req deasserted in the ACCESS cycle.
  - Required: cpu_done still pulses; FSM returns to IDLE and stays idle.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one fixed-latency memory port between CPU and DMA.
module mem_arbiter #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned LATENCY = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cpu_req,
   input  logic             cpu_we,
   input  logic [WIDTH-1:0] cpu_addr,
   input  logic [WIDTH-1:0] cpu_wdata,
   output logic [WIDTH-1:0] cpu_rdata,
   output logic             cpu_done,
   input  logic             dma_req,
   input  logic             dma_we,
   input  logic [WIDTH-1:0] dma_addr,
   input  logic [WIDTH-1:0] dma_wdata,
   output logic [WIDTH-1:0] dma_rdata,
   output logic             dma_done,
   output logic             mem_en,
   output logic             mem_we,
   output logic [WIDTH-1:0] mem_addr,
   output logic [WIDTH-1:0] mem_wdata,
   input  logic [WIDTH-1:0] mem_rdata,
   output logic             owner
);

   localparam int unsigned CW = 4;

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t           state, state_n;
   logic [CW-1:0]    cnt, cnt_n;
   logic             owner_n, win;
   logic             en_n, we_n, cpu_done_n, dma_done_n;
   logic [WIDTH-1:0] addr_n, wdata_n, cpu_rdata_n, dma_rdata_n;

   // State and all registered outputs; reset aborts any in-flight access.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         owner     <= 1'b1;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         cpu_rdata <= '0;
         dma_rdata <= '0;
         cpu_done  <= 1'b0;
         dma_done  <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         owner     <= owner_n;
         mem_en    <= en_n;
         mem_we    <= we_n;
         mem_addr  <= addr_n;
         mem_wdata <= wdata_n;
         cpu_rdata <= cpu_rdata_n;
         dma_rdata <= dma_rdata_n;
         cpu_done  <= cpu_done_n;
         dma_done  <= dma_done_n;
      end
   end

   // Next-state: grant in IDLE, count down the access, pulse done in RESP.
   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      owner_n     = owner;
      win         = owner;
      en_n        = mem_en;
      we_n        = mem_we;
      addr_n      = mem_addr;
      wdata_n     = mem_wdata;
      cpu_rdata_n = cpu_rdata;
      dma_rdata_n = dma_rdata;
      cpu_done_n  = 1'b0;
      dma_done_n  = 1'b0;
      case (state)
         IDLE: begin
            if (cpu_req || dma_req) begin
               // On a tie the requester not served last time wins.
               win     = (cpu_req && dma_req) ? ~owner : dma_req;
               owner_n = win;
               addr_n  = win ? dma_addr  : cpu_addr;
               wdata_n = win ? dma_wdata : cpu_wdata;
               we_n    = win ? dma_we    : cpu_we;
               en_n    = 1'b1;
               cnt_n   = CW'(LATENCY - 1);
               state_n = ACCESS;
            end
         end
         ACCESS: begin
            if (cnt == '0) begin
               if (!mem_we) begin
                  if (owner) dma_rdata_n = mem_rdata;
                  else       cpu_rdata_n = mem_rdata;
               end
               if (owner) dma_done_n = 1'b1;
               else       cpu_done_n = 1'b1;
               en_n    = 1'b0;
               we_n    = 1'b0;
               state_n = RESP;
            end else begin
               cnt_n = cnt - CW'(1);
            end
         end
         RESP:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: LATENCY=2 main instance plus a LATENCY=1 build.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        cpu_req, cpu_we, dma_req, dma_we;
   logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
   logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata, mem_rdata;
   logic        cpu_done, dma_done, mem_en, mem_we, owner;
   logic [3:0]  age;

   logic        l1_cpu_req;
   logic [31:0] l1_cpu_addr;
   logic [31:0] l1_cpu_rdata, l1_dma_rdata, l1_mem_addr, l1_mem_wdata, l1_mem_rdata;
   logic        l1_cpu_done, l1_dma_done, l1_mem_en, l1_mem_we, l1_owner;
   logic [3:0]  l1_age;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.WIDTH(32), .LATENCY(2)) u_dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_done(cpu_done),
      .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .dma_rdata(dma_rdata), .dma_done(dma_done),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .owner(owner)
   );

   mem_arbiter #(.WIDTH(32), .LATENCY(1)) u_l1 (
      .clk(clk), .reset(reset),
      .cpu_req(l1_cpu_req), .cpu_we(1'b0), .cpu_addr(l1_cpu_addr), .cpu_wdata(32'h0),
      .cpu_rdata(l1_cpu_rdata), .cpu_done(l1_cpu_done),
      .dma_req(1'b0), .dma_we(1'b0), .dma_addr(32'h0), .dma_wdata(32'h0),
      .dma_rdata(l1_dma_rdata), .dma_done(l1_dma_done),
      .mem_en(l1_mem_en), .mem_we(l1_mem_we), .mem_addr(l1_mem_addr), .mem_wdata(l1_mem_wdata),
      .mem_rdata(l1_mem_rdata), .owner(l1_owner)
   );

   // Memory contents seen by both instances.
   function automatic logic [31:0] mem_val(input logic [31:0] a);
      case (a)
         32'h10:  return 32'hDEADBEEF;
         32'h04:  return 32'h11110004;
         32'h08:  return 32'h22220008;
         32'h00:  return 32'hA5A5A5A5;
         default: return 32'h0F0F0F0F;
      endcase
   endfunction

   // Cycles mem_en has been high; data is valid only LATENCY cycles into the access.
   always_ff @(posedge clk) begin
      age    <= mem_en    ? age + 4'd1    : 4'd0;
      l1_age <= l1_mem_en ? l1_age + 4'd1 : 4'd0;
   end

   assign mem_rdata    = (mem_en && age == 4'd1)       ? mem_val(mem_addr)    : 32'hBAD0BAD0;
   assign l1_mem_rdata = (l1_mem_en && l1_age == 4'd0) ? mem_val(l1_mem_addr) : 32'hBAD0BAD0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1;
      cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
      dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
      l1_cpu_req = 0; l1_cpu_addr = 0;
      tick(); tick();
      reset = 1'b0;
      tick();

      // Reset state
      check("rst_mem_en", 32'(mem_en), 32'd0);
      check("rst_owner", 32'(owner), 32'd1);
      check("rst_done", {30'd0, cpu_done, dma_done}, 32'd0);
      check("rst_addr", mem_addr, 32'h0);
      check("rst_rdata", cpu_rdata | dma_rdata, 32'h0);

      // Single CPU read, cycle 0 = this cycle
      cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
      tick();
      check("rd_c1_en", 32'(mem_en), 32'd1);
      check("rd_c1_addr", mem_addr, 32'h10);
      check("rd_c1_owner", 32'(owner), 32'd0);
      check("rd_c1_done", 32'(cpu_done), 32'd0);
      tick();
      check("rd_c2_en", 32'(mem_en), 32'd1);
      check("rd_c2_we", 32'(mem_we), 32'd0);
      check("rd_c2_done", 32'(cpu_done), 32'd0);
      tick();
      check("rd_c3_en", 32'(mem_en), 32'd0);
      check("rd_c3_done", 32'(cpu_done), 32'd1);
      check("rd_c3_rdata", cpu_rdata, 32'hDEADBEEF);
      check("rd_c3_dma_rdata", dma_rdata, 32'h0);
      cpu_req = 0;
      tick();
      check("rd_c4_done", 32'(cpu_done), 32'd0);
      check("rd_c4_en", 32'(mem_en), 32'd0);

      // Simultaneous requests right after reset: CPU, DMA, CPU, DMA
      reset = 1'b1; tick(); reset = 1'b0; tick();
      cpu_req = 1; cpu_addr = 32'h4;
      dma_req = 1; dma_addr = 32'h8;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("rr_owner", 32'(owner), 32'(i % 2));
         check("rr_addr", mem_addr, (i % 2 == 1) ? 32'h8 : 32'h4);
         check("rr_en", 32'(mem_en), 32'd1);
         tick();
         check("rr_nodone", {30'd0, cpu_done, dma_done}, 32'd0);
         tick();
         check("rr_done", {30'd0, cpu_done, dma_done}, (i % 2 == 1) ? 32'd1 : 32'd2);
         if (i == 3) begin
            cpu_req = 0; dma_req = 0;
         end
         tick();
         check("rr_idle_done", {30'd0, cpu_done, dma_done}, 32'd0);
      end
      check("rr_cpu_rdata", cpu_rdata, 32'h11110004);
      check("rr_dma_rdata", dma_rdata, 32'h22220008);

      // DMA write leaves both rdata registers untouched
      dma_req = 1; dma_we = 1; dma_addr = 32'h20; dma_wdata = 32'h12345678;
      tick();
      check("wr_en", 32'(mem_en), 32'd1);
      check("wr_we", 32'(mem_we), 32'd1);
      check("wr_addr", mem_addr, 32'h20);
      check("wr_wdata", mem_wdata, 32'h12345678);
      check("wr_owner", 32'(owner), 32'd1);
      tick();
      check("wr_we2", 32'(mem_we), 32'd1);
      tick();
      check("wr_done", {30'd0, cpu_done, dma_done}, 32'd1);
      check("wr_we_off", 32'(mem_we), 32'd0);
      check("wr_dma_rdata", dma_rdata, 32'h22220008);
      check("wr_cpu_rdata", cpu_rdata, 32'h11110004);
      dma_req = 0; dma_we = 0;
      tick();

      // CPU drops req during ACCESS; transaction still completes
      cpu_req = 1; cpu_addr = 32'h10;
      tick();
      cpu_req = 0;
      check("drop_en", 32'(mem_en), 32'd1);
      tick();
      tick();
      check("drop_done", 32'(cpu_done), 32'd1);
      check("drop_rdata", cpu_rdata, 32'hDEADBEEF);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("drop_idle", {29'd0, mem_en, cpu_done, dma_done}, 32'd0);
      end

      // Reset in the first ACCESS cycle of a CPU read
      cpu_req = 1; cpu_addr = 32'h4;
      tick();
      check("ra_en_before", 32'(mem_en), 32'd1);
      reset = 1'b1;
      #1;
      check("ra_en_async", 32'(mem_en), 32'd0);
      check("ra_owner", 32'(owner), 32'd1);
      check("ra_rdata", cpu_rdata, 32'h0);
      cpu_req = 0;
      tick();
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("ra_nodone", {30'd0, cpu_done, dma_done}, 32'd0);
      end
      cpu_req = 1; cpu_addr = 32'h8;
      tick(); tick(); tick();
      check("ra_new_done", 32'(cpu_done), 32'd1);
      check("ra_new_rdata", cpu_rdata, 32'h22220008);
      cpu_req = 0;
      tick();

      // LATENCY=1 build
      l1_cpu_req = 1; l1_cpu_addr = 32'h0;
      tick();
      check("l1_c1_en", 32'(l1_mem_en), 32'd1);
      check("l1_c1_done", 32'(l1_cpu_done), 32'd0);
      tick();
      check("l1_c2_en", 32'(l1_mem_en), 32'd0);
      check("l1_c2_done", 32'(l1_cpu_done), 32'd1);
      check("l1_c2_rdata", l1_cpu_rdata, 32'hA5A5A5A5);
      l1_cpu_req = 0;
      tick();
      check("l1_c3_done", 32'(l1_cpu_done), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
